// File: rtl/mem_access_unit.sv
// Load/store controller: byte/half/word requests to a word-only data memory, with
// read-modify-write for sub-word stores. Define MAU_ALIGN_CHECK_EN to enable error detection.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic        req_err;

`ifdef MAU_ALIGN_CHECK_EN
  assign req_err = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign req_err = 1'b0;
`endif

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] a, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: return word;  // size 11 only reaches here when unchecked: treated as word
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wd,
                                              input logic [1:0] size, input logic [1:0] a);
    logic [31:0] m;
    m = word;
    if (size == 2'b00) begin
      case (a)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (a[1]) begin
      m[31:16] = wd;
    end else begin
      m[15:0] = wd;
    end
    return m;
  endfunction

  always_comb begin
    state_d      = state_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata[15:0];
          if (req_err) begin
            state_d      = RESP;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (!req_write) begin
            state_d = LOAD;
          end else if (req_size == 2'b00 || req_size == 2'b01) begin
            state_d = RMW_RD;
          end else begin
            state_d = STORE;
            merge_d = req_wdata;
          end
        end
      end
      LOAD: begin
        resp_rdata_d = load_extract(mem_rdata, size_q, addr_q[1:0], sgn_q);
        resp_error_d = 1'b0;
        state_d      = RESP;
      end
      RMW_RD: begin
        merge_d = store_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
        state_d = STORE;
      end
      STORE: begin
        resp_rdata_d = 32'h0;
        resp_error_d = 1'b0;
        state_d      = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Request capture and merge word: datapath, no reset needed since outputs are gated by state
  always_ff @(posedge clk) begin
    size_q  <= size_d;
    sgn_q   <= sgn_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    merge_q <= merge_d;
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign mem_read   = (state_q == LOAD) || (state_q == RMW_RD);
  assign mem_write  = (state_q == STORE);
  assign mem_addr   = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = mem_write ? merge_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, handshake and reset sequences,
// then randomized requests against a byte-lane reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hCAFE0001;
    mem[1] = 32'h11223344;
    forever begin
      @(posedge clk);
      if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: a request touches nbytes bytes starting at the address rounded down to nbytes
  task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int lat, output int nrd, output int nwr);
    int nbytes, off, eff, idx;
    logic [31:0] mask, v;
    eff = int'(sz);
`ifdef MAU_ALIGN_CHECK_EN
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
    err = 1'b0;
    if (sz == 2'd3) eff = 2;
`endif
    rd = 32'h0; lat = 1; nrd = 0; nwr = 0;
    if (err) return;
    nbytes = 1 << eff;
    off    = (int'(a[1:0]) / nbytes) * nbytes;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    idx    = int'(a[7:2]);
    if (!w) begin
      v = (ref_mem[idx] >> (8 * off)) & mask;
      if (sg && v[8 * nbytes - 1]) v = v | ~mask;
      rd = v; lat = 2; nrd = 1;
    end else begin
      ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      nwr = 1;
      if (nbytes == 4) lat = 2;
      else begin lat = 3; nrd = 1; end
    end
  endtask

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat, output int nrd, output int nwr,
                         output logic [31:0] seen_addr, output logic [31:0] held);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    check("ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_signed = ~sg; req_addr = $urandom; req_wdata = $urandom;
    rd = 32'h0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; seen_addr = 32'h0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_read)  begin nrd++; seen_addr = mem_addr; end
      if (mem_write) begin nwr++; seen_addr = mem_addr; end
      if (resp_valid) begin lat = c; rd = resp_rdata; err = resp_error; end
    end
    @(negedge clk);
    held = resp_rdata;
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] rd, seen, held, e_rd;
    logic        err, e_err, w, sg;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    int lat, nrd, nwr, e_lat, e_nrd, e_nwr, cnt, bad;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0,        1'b0, 2};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[2]  = '{1'b1, 2'd0, 1'b1, 32'h6, 32'h000000AA, 32'h0,        1'b0, 3};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h6, 32'h0,        32'hFFFFFFAA, 1'b0, 2};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h6, 32'h0,        32'h000000AA, 1'b0, 2};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h6, 32'h0,        32'h000011AA, 1'b0, 2};
`ifdef MAU_ALIGN_CHECK_EN
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h5, 32'h0,        32'h0,        1'b1, 1};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h2, 32'h0,        32'h0,        1'b1, 1};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h4, 32'h0,        32'h0,        1'b1, 1};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h3, 32'h5A5A5A5A, 32'h0,        1'b1, 1};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0,        32'hCAFE0001, 1'b0, 2};
`else
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h5, 32'h0,        32'h00003344, 1'b0, 2};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h2, 32'h0,        32'hCAFE0001, 1'b0, 2};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h4, 32'h0,        32'h11AA3344, 1'b0, 2};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h3, 32'h5A5A5A5A, 32'h0,        1'b0, 2};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0,        32'h5A5A5A5A, 1'b0, 2};
`endif
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'hA, 32'h1234BEEF, 32'h0,        1'b0, 3};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,        32'hBEEFBEEF, 1'b0, 2};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h7, 32'h0,        32'h00000011, 1'b0, 2};

    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    ref_mem[0] = 32'hCAFE0001;
    ref_mem[1] = 32'h11223344;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset_resp_error", {31'b0, resp_error}, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_mem_ctrl", {30'b0, mem_read, mem_write}, 32'd0);
    check("reset_mem_addr_wdata", mem_addr | mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      run_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata,
              rd, err, lat, nrd, nwr, seen, held);
      model(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata,
            e_rd, e_err, e_lat, e_nrd, e_nwr);
      e_nrd = (!vecs[i].exp_err && (!vecs[i].w || vecs[i].exp_lat == 3)) ? 1 : 0;
      e_nwr = (!vecs[i].exp_err && vecs[i].w) ? 1 : 0;
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_error", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_mem_reads", i), 32'(nrd), 32'(e_nrd));
      check($sformatf("vec%0d_mem_writes", i), 32'(nwr), 32'(e_nwr));
      check($sformatf("vec%0d_rdata_hold", i), held, vecs[i].exp_rdata);
      if (e_nrd + e_nwr > 0)
        check($sformatf("vec%0d_mem_addr", i), seen, {vecs[i].addr[31:2], 2'b00});
    end
    check("mem_word4_after_rmw", mem[1], 32'h11AA3344);
    check("mem_word8_after_rmw", mem[2], 32'hBEEFBEEF);

    // Busy store with req_valid held and the request fields changing
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h11111111;
    @(posedge clk);
    #1;
    req_addr = 32'h14; req_wdata = 32'h22222222;
    lat = 0; nwr = 0; bad = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_write) begin nwr++; if (mem_addr != 32'h10) bad++; end
      if (resp_valid) lat = c;
    end
    check("hs_first_latency", 32'(lat), 32'd2);
    check("hs_first_writes", 32'(nwr), 32'd1);
    check("hs_first_wrong_addr", 32'(bad), 32'd0);
    check("hs_first_mem", mem[4], 32'h11111111);
    check("hs_second_not_yet", mem[5], 32'h0);
    check("hs_busy_in_resp", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("hs_ready_after_resp", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (resp_valid) lat = c;
    end
    check("hs_second_latency", 32'(lat), 32'd2);
    check("hs_second_mem", mem[5], 32'h22222222);
    check("hs_first_kept", mem[4], 32'h11111111);
    model(1'b1, 2'd2, 1'b0, 32'h10, 32'h11111111, e_rd, e_err, e_lat, e_nrd, e_nwr);
    model(1'b1, 2'd2, 1'b0, 32'h14, 32'h22222222, e_rd, e_err, e_lat, e_nrd, e_nwr);

    // Reset during the read phase of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h4; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_rmw_read", {31'b0, mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_mem_ctrl", {30'b0, mem_read, mem_write}, 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || mem_write) cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || mem_write) cnt++;
    end
    check("rst_mid_no_resp_or_write", 32'(cnt), 32'd0);
    check("rst_mid_mem_unchanged", mem[1], 32'h11AA3344);

    // Randomized requests against the reference model
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 255);
      wd = $urandom;
      model(w, sz, sg, a, wd, e_rd, e_err, e_lat, e_nrd, e_nwr);
      run_req(w, sz, sg, a, wd, rd, err, lat, nrd, nwr, seen, held);
      check($sformatf("rnd%0d_rdata", i), rd, e_rd);
      check($sformatf("rnd%0d_error", i), {31'b0, err}, {31'b0, e_err});
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(e_lat));
      check($sformatf("rnd%0d_mem_ops", i), 32'(nrd * 16 + nwr), 32'(e_nrd * 16 + e_nwr));
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("final_memory_mismatched_words", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
